bcd_conv_scheduler: RTL

Shares one iterative (subtract-and-count) binary-to-BCD converter between up to four requesters, such as fuzzy-controller display channels. A round-robin arbiter grants one request at a time and captures the requester's 12-bit binary value. It then sequences the conversion and returns four BCD digits tagged with the requester index. It sits between the fuzzy datapath outputs and the seven-segment display drivers.

---
 rtl/bcd_sched_pkg.sv | 18 +
 rtl/bcd_iter_conv.sv | 82 ++++++++
 rtl/bcd_conv_scheduler.sv | 97 +++++++++
 3 files changed

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD conversion scheduler.
package bcd_sched_pkg;

    localparam int W      = 12;
    localparam int DIGITS = 4;

    localparam logic [W-1:0] DEC1000 = 12'd1000;
    localparam logic [W-1:0] DEC100  = 12'd100;
    localparam logic [W-1:0] DEC10   = 12'd10;

    typedef enum logic {
        IDLE,
        CONV
    } conv_state_t;

    typedef logic [4*DIGITS-1:0] bcd4_t;

endpackage

// File: rtl/bcd_iter_conv.sv
// Iterative subtract-and-count binary-to-BCD converter, one decade subtraction per cycle.
module bcd_iter_conv
    import bcd_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         ready,
    output logic         done,
    output bcd4_t        digits
);

    conv_state_t  r_state;
    conv_state_t  w_state_next;
    logic [W-1:0] r_rem;
    logic [3:0]   r_d3;
    logic [3:0]   r_d2;
    logic [3:0]   r_d1;
    logic         r_done;
    bcd4_t        r_digits;
    logic         w_last_step;

    // The final step publishes the result and can accept a new value on the same edge.
    assign w_last_step = (r_state == CONV) && (r_rem < DEC10);
    assign busy        = (r_state == CONV);
    assign ready       = (r_state == IDLE) || w_last_step;
    assign done        = r_done;
    assign digits      = r_digits;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = CONV;
            CONV:    if (w_last_step && !start) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_d3     <= '0;
            r_d2     <= '0;
            r_d1     <= '0;
            r_done   <= 1'b0;
            r_digits <= '0;
        end else begin
            r_done <= w_last_step;
            if (w_last_step) begin
                r_digits <= {r_d3, r_d2, r_d1, r_rem[3:0]};
            end
            if (start && ready) begin
                r_rem <= value;
                r_d3  <= '0;
                r_d2  <= '0;
                r_d1  <= '0;
            end else if (r_state == CONV) begin
                if (r_rem >= DEC1000) begin
                    r_d3  <= r_d3 + 4'd1;
                    r_rem <= r_rem - DEC1000;
                end else if (r_rem >= DEC100) begin
                    r_d2  <= r_d2 + 4'd1;
                    r_rem <= r_rem - DEC100;
                end else if (r_rem >= DEC10) begin
                    r_d1  <= r_d1 + 4'd1;
                    r_rem <= r_rem - DEC10;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin arbiter sharing one iterative BCD converter between up to four requesters.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_val,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_id,
    output logic [15:0]        bcd_out
);

    logic [1:0]       r_last_winner;
    logic [1:0]       r_done_id;
    logic [N_REQ-1:0] r_gnt;
    logic [1:0]       w_win;
    logic [2:0]       w_sum;
    logic             w_any;
    logic             w_start;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_finish;
    logic [W-1:0]     w_value;
    bcd4_t            w_digits;

    // Scan from the highest offset down so the nearest requester after the last winner wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            w_sum = {1'b0, r_last_winner} + 3'(off);
            if (w_sum >= 3'(N_REQ)) begin
                w_sum = w_sum - 3'(N_REQ);
            end
            if (req[w_sum[1:0]]) begin
                w_any = 1'b1;
                w_win = w_sum[1:0];
            end
        end
    end

    always_comb begin
        w_value = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == 2'(i)) begin
                w_value = req_val[i*W +: W];
            end
        end
    end

    assign w_start  = w_any && w_ready;
    assign w_finish = w_busy && w_ready;

    // Only one conversion is ever in flight, so the last winner doubles as the current id.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt         <= '0;
            r_last_winner <= 2'(N_REQ - 1);
            r_done_id     <= '0;
        end else begin
            r_gnt <= '0;
            if (w_start) begin
                r_gnt[w_win]  <= 1'b1;
                r_last_winner <= w_win;
            end
            if (w_finish) begin
                r_done_id <= r_last_winner;
            end
        end
    end

    bcd_iter_conv u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .value  (w_value),
        .busy   (w_busy),
        .ready  (w_ready),
        .done   (w_done),
        .digits (w_digits)
    );

    assign gnt     = r_gnt;
    assign busy    = w_busy;
    assign done    = w_done;
    assign done_id = r_done_id;
    assign bcd_out = w_digits;

endmodule
